sort_stream_ctrl: RTL and testbench
===================================

Name: sort_stream_ctrl

Overview:
Sequencing controller for the 32-entry u8 parallel sorter, which is instantiated beside this block. It collects a frame of up to NUM bytes from a valid/ready input stream and pads short frames. It then fires the sorter with a one-cycle vld_in pulse, captures the sorted vector on vld_out, and drains the real entries as a valid/ready output stream with a last marker.

Parameters:
W_DATA, 8, element width in bits.
NUM, 32, sorter width, i.e. entries per frame.
W_CNT, 6, counter width; must satisfy 2^W_CNT > NUM.
SORT_TMO, 16, maximum cycles from the fire pulse to sort_vld_out before abort.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input element valid
s_ready  out  1  controller accepts input element
s_data  in  W_DATA  input element
s_last  in  1  final element of frame (may arrive before NUM elements)
sort_vld_in  out  1  one-cycle fire pulse to sorter
sort_din  out  NUM*W_DATA  sorter inputs, element i at [i*W_DATA +: W_DATA]
sort_vld_out  in  1  sorter result valid
sort_dout  in  NUM*W_DATA  sorter outputs, ascending, element 0 is smallest
m_valid  out  1  output element valid
m_ready  in  1  downstream accepts output element
m_data  out  W_DATA  output element
m_last  out  1  final output element of frame
busy  out  1  high in any state except LOAD with load count 0
err_tmo  out  1  sticky sorter-timeout flag; cleared only by reset

Behaviour:
- Reset is asynchronous and active-low; the design has one clock domain.
- Reset values: s_ready=0, sort_vld_in=0, sort_din=0, m_valid=0, m_data=0, m_last=0, busy=0, err_tmo=0, state=LOAD, counters=0.
- s_ready is 1 in the cycle after reset deasserts (state LOAD).
- FSM states: LOAD, FIRE, WAIT, DRAIN.
- LOAD:
  - s_ready=1. Each s_valid&&s_ready handshake writes s_data into buffer slot ld_cnt, then ld_cnt++.
  - Exit to FIRE on a handshake with s_last=1, or when the handshake fills slot NUM-1.
  - Slots at index >= ld_cnt are forced to all-ones (2^W_DATA-1), so pads sort to the top.
  - frame_len = final ld_cnt (1..NUM). A frame is never empty.
- FIRE:
  - s_ready=0. sort_vld_in=1 for exactly one cycle; sort_din holds the buffer, stable from this cycle until the next LOAD write.
  - Next state is WAIT; the timeout counter clears.
- WAIT:
  - On sort_vld_out=1, capture sort_dout into the result register, clear rd_idx, go to DRAIN.
  - If SORT_TMO cycles elapse with no sort_vld_out: set err_tmo, discard the frame, clear ld_cnt, go to LOAD.
  - sort_vld_out outside WAIT is ignored.
- DRAIN:
  - m_valid=1; m_data = result[rd_idx]; m_last = (rd_idx == frame_len-1).
  - On m_valid&&m_ready: if m_last, go to LOAD with ld_cnt=0; else rd_idx++.
  - While m_ready=0, m_valid, m_data and m_last hold stable (AXI-stream rule).
  - Pads are never output. Exactly frame_len beats are emitted.
- Throughput: single-buffered; input stalls from FIRE until the last output beat.
- Minimum frame-to-frame overhead: 2 cycles (FIRE, WAIT) plus sorter latency.
- Reset mid-operation: all state aborts immediately to reset values. No partial output continues after release.
- Equal values, including real 0xFF equal to the pad value, are output in any stable order. Values are correct because the entries are equal.

Optional Feature:
Macro SORT_DESCEND_EN.
- Defined: DRAIN reads result indices frame_len-1 down to 0, giving descending output. m_last is asserted at index 0. Pads are still excluded.
- Undefined: ascending output, indices 0 to frame_len-1.
- Port list and timing are identical in both builds.

Test Plan:
- Full frame: 32 elements 31,29,...,1,2,2,4,4,4,4,8,16,8,16,32,32,0,10,20,30 with m_ready=1. Expect one sort_vld_in pulse, then 32 beats 0,1,2,2,3,4,4,4,4,5,... ending 32,32, m_last on beat 32, err_tmo=0.
- Short frame: 5,250,0,7 with s_last on element 4. Expect sort_din slots 4..31 = 0xFF and output 0,5,7,250 with m_last on the 4th beat. With SORT_DESCEND_EN: 250,7,5,0.
- Backpressure: toggle m_ready 1-0-0-1 randomly during DRAIN. Expect m_data/m_last stable while stalled, no lost or duplicated beats, s_ready=0 until the final beat.
- Timeout: sorter model never asserts vld_out. Expect err_tmo=1 after SORT_TMO cycles in WAIT, return to LOAD (s_ready=1), no m_valid; a following frame still sorts correctly and err_tmo stays 1.
- Reset mid-DRAIN: assert rst_n=0 after output beat 10. Expect m_valid=0 and busy=0 asynchronously; after release, a new 3-element frame 3,1,2 produces 1,2,3.
- Pad tie: frame 255,255,1 with s_last. Expect output 1,255,255, exactly 3 beats.

Source files
------------

// File: rtl/sort_stream_ctrl_if.sv
`timescale 1ns/1ps
// Stream and sorter-side signal bundle for sort_stream_ctrl; master is the controller's view.
interface sort_stream_ctrl_if #(
    parameter int W_DATA = 8,
    parameter int NUM    = 32
);
    logic                    s_valid;
    logic                    s_ready;
    logic [W_DATA-1:0]       s_data;
    logic                    s_last;
    logic                    sort_vld_in;
    logic [NUM*W_DATA-1:0]   sort_din;
    logic                    sort_vld_out;
    logic [NUM*W_DATA-1:0]   sort_dout;
    logic                    m_valid;
    logic                    m_ready;
    logic [W_DATA-1:0]       m_data;
    logic                    m_last;

    modport master (
        input  s_valid, s_data, s_last, sort_vld_out, sort_dout, m_ready,
        output s_ready, sort_vld_in, sort_din, m_valid, m_data, m_last
    );

    modport slave (
        output s_valid, s_data, s_last, sort_vld_out, sort_dout, m_ready,
        input  s_ready, sort_vld_in, sort_din, m_valid, m_data, m_last
    );
endinterface

// File: rtl/sort_stream_ctrl.sv
`timescale 1ns/1ps
// Frame sequencer for the parallel u8 sorter: load+pad, fire, await result, drain real entries (SORT_DESCEND_EN: descending drain).
// Latency: frame_len input beats, FIRE, WAIT for sorter, then one beat/cycle; input stalls from FIRE until the final output beat.
module sort_stream_ctrl #(
    parameter int W_DATA   = 8,
    parameter int NUM      = 32,
    parameter int W_CNT    = 6,
    parameter int SORT_TMO = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    sort_stream_ctrl_if.master bus,
    output logic               busy,
    output logic               err_tmo
);
    localparam int W_IDX = $clog2(NUM);
    localparam int W_TMO = $clog2(SORT_TMO + 1);

    typedef enum logic [1:0] {LOAD, FIRE, WAIT, DRAIN} state_t;

    state_t                     state_q, state_d;
    logic [W_CNT-1:0]           ld_cnt_q, ld_cnt_d;
    logic [W_IDX-1:0]           rd_idx_q, rd_idx_d;
    logic [W_TMO-1:0]           tmo_cnt_q, tmo_cnt_d;
    logic                       err_tmo_q, err_tmo_d;
    logic                       s_ready_q;
    logic [NUM-1:0][W_DATA-1:0] din_q, din_d;
    logic [NUM-1:0][W_DATA-1:0] res_q, res_d;

    logic             s_hs;
    logic             ld_done;
    logic             rd_last;
    logic [W_CNT-1:0] last_cnt;
    logic [W_IDX-1:0] rd_first;
    logic [W_IDX-1:0] rd_next;

    assign s_hs     = bus.s_valid && s_ready_q;
    assign ld_done  = s_hs && (bus.s_last || (ld_cnt_q == W_CNT'(NUM - 1)));
    assign last_cnt = ld_cnt_q - W_CNT'(1);

`ifdef SORT_DESCEND_EN
    assign rd_first = W_IDX'(last_cnt);
    assign rd_last  = (rd_idx_q == '0);
    assign rd_next  = rd_idx_q - W_IDX'(1);
`else
    assign rd_first = '0;
    assign rd_last  = (W_CNT'(rd_idx_q) == last_cnt);
    assign rd_next  = rd_idx_q + W_IDX'(1);
`endif

    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        rd_idx_d  = rd_idx_q;
        tmo_cnt_d = tmo_cnt_q;
        err_tmo_d = err_tmo_q;
        din_d     = din_q;
        res_d     = res_q;
        case (state_q)
            LOAD: begin
                if (s_hs) begin
                    din_d[ld_cnt_q[W_IDX-1:0]] = bus.s_data;
                    ld_cnt_d = ld_cnt_q + W_CNT'(1);
                end
                // Pads are written as all-ones on the closing beat so they sort above every real entry.
                if (ld_done) begin
                    for (int i = 0; i < NUM; i++) begin
                        if (W_CNT'(i) > ld_cnt_q) din_d[i] = '1;
                    end
                    state_d = FIRE;
                end
            end
            FIRE: begin
                tmo_cnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (bus.sort_vld_out) begin
                    res_d    = bus.sort_dout;
                    rd_idx_d = rd_first;
                    state_d  = DRAIN;
                end else if (tmo_cnt_q == W_TMO'(SORT_TMO - 1)) begin
                    err_tmo_d = 1'b1;
                    ld_cnt_d  = '0;
                    state_d   = LOAD;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + W_TMO'(1);
                end
            end
            DRAIN: begin
                if (bus.m_ready) begin
                    if (rd_last) begin
                        ld_cnt_d = '0;
                        state_d  = LOAD;
                    end else begin
                        rd_idx_d = rd_next;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            ld_cnt_q  <= '0;
            rd_idx_q  <= '0;
            tmo_cnt_q <= '0;
            err_tmo_q <= 1'b0;
            s_ready_q <= 1'b0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            ld_cnt_q  <= ld_cnt_d;
            rd_idx_q  <= rd_idx_d;
            tmo_cnt_q <= tmo_cnt_d;
            err_tmo_q <= err_tmo_d;
            s_ready_q <= (state_d == LOAD);
            din_q     <= din_d;
        end
    end

    // Result storage is only observed in DRAIN, which always follows a capture.
    always_ff @(posedge clk) begin
        res_q <= res_d;
    end

    assign bus.s_ready     = s_ready_q;
    assign bus.sort_vld_in = (state_q == FIRE);
    assign bus.sort_din    = din_q;
    assign bus.m_valid     = (state_q == DRAIN);
    assign bus.m_data      = (state_q == DRAIN) ? res_q[rd_idx_q] : '0;
    assign bus.m_last      = (state_q == DRAIN) && rd_last;
    assign busy            = !((state_q == LOAD) && (ld_cnt_q == '0));
    assign err_tmo         = err_tmo_q;
endmodule

// File: tb/tb_sort_stream_ctrl.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for sort_stream_ctrl with a behavioural sorter beside it.
module tb_sort_stream_ctrl;
    localparam int NUM      = 32;
    localparam int SORT_TMO = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    logic err_tmo;

    always #5 clk = ~clk;

    sort_stream_ctrl_if #(.W_DATA(8), .NUM(NUM)) bus ();

    sort_stream_ctrl #(
        .W_DATA(8), .NUM(NUM), .W_CNT(6), .SORT_TMO(SORT_TMO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy   (busy),
        .err_tmo(err_tmo)
    );

    int n_chk = 0;
    int n_err = 0;
    int beats_done = 0;
    int cd = 0;
    int t_wait;
    int lat;
    bit bp = 0;
    bit dead = 0;
    bit gaps = 0;
    bit prev_in = 0;
    bit hold_vld = 0;
    logic [7:0]   hold_dat;
    logic         hold_last;
    time          fire_t;
    logic [7:0]   frm[$];
    logic [7:0]   v[$];
    logic [8:0]   exp_q[$];
    logic [255:0] exp_din[$];
    logic [255:0] res;
    logic [255:0] ed;
    logic [8:0]   e;
    logic [7:0]   tail16 [16] = '{8'd2, 8'd2, 8'd4, 8'd4, 8'd4, 8'd4, 8'd8, 8'd16,
                                  8'd8, 8'd16, 8'd32, 8'd32, 8'd0, 8'd10, 8'd20, 8'd30};

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, expv);
        end
    endtask

    // Reference: expected sorter input is the frame padded with 0xFF; expected output is the frame sorted.
    task automatic send_frame(input bit expect_out);
        logic [7:0]   s[$];
        logic [255:0] dv;
        int n;
        n = frm.size();
        s = frm;
        s.sort();
`ifdef SORT_DESCEND_EN
        s.reverse();
`endif
        dv = '1;
        for (int i = 0; i < n; i++) dv[i*8 +: 8] = frm[i];
        exp_din.push_back(dv);
        if (expect_out) begin
            for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), s[i]});
        end
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.s_valid = 1'b0;
                @(negedge clk);
            end
            bus.s_valid = 1'b1;
            bus.s_data  = frm[i];
            bus.s_last  = (i == n - 1);
            while (!bus.s_ready && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 2000) chk("s_ready_wait", 256'(bus.s_ready), 256'(1));
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_drained"}, 256'(t < 3000), 256'(1));
    endtask

    task automatic rand_frame(input int n);
        frm.delete();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) frm.push_back(8'hFF);
            else frm.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    // Behavioural sorter: random latency, optionally never answers.
    initial begin
        bus.sort_vld_out = 1'b0;
        bus.sort_dout    = '0;
        forever begin
            @(negedge clk);
            bus.sort_vld_out = 1'b0;
            if (!rst_n) begin
                cd      = 0;
                prev_in = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0 && !dead) begin
                        bus.sort_vld_out = 1'b1;
                        bus.sort_dout    = res;
                    end
                end
                if (bus.sort_vld_in) begin
                    chk("fire_single_cycle", 256'(prev_in), 256'(0));
                    chk("fire_expected", 256'(exp_din.size() != 0), 256'(1));
                    if (exp_din.size() != 0) begin
                        ed = exp_din.pop_front();
                        chk("sort_din", bus.sort_din, ed);
                    end
                    v.delete();
                    for (int i = 0; i < NUM; i++) v.push_back(bus.sort_din[i*8 +: 8]);
                    v.sort();
                    for (int i = 0; i < NUM; i++) res[i*8 +: 8] = v[i];
                    cd     = $urandom_range(1, 4);
                    fire_t = $time;
                end
                prev_in = bus.sort_vld_in;
            end
        end
    end

    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: the values seen here are the ones the next rising edge samples.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                hold_vld = 0;
            end else begin
                if (hold_vld) begin
                    chk("stall_valid", 256'(bus.m_valid), 256'(1));
                    chk("stall_data", 256'(bus.m_data), 256'(hold_dat));
                    chk("stall_last", 256'(bus.m_last), 256'(hold_last));
                end
                if (bus.m_valid) begin
                    chk("s_ready_in_drain", 256'(bus.s_ready), 256'(0));
                    if (bus.m_ready) begin
                        hold_vld = 0;
                        chk("beat_expected", 256'(exp_q.size() != 0), 256'(1));
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk("m_data", 256'(bus.m_data), 256'(e[7:0]));
                            chk("m_last", 256'(bus.m_last), 256'(e[8]));
                            beats_done++;
                        end
                    end else begin
                        hold_vld  = 1;
                        hold_dat  = bus.m_data;
                        hold_last = bus.m_last;
                    end
                end else begin
                    hold_vld = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        #3;
        chk("rst_s_ready", 256'(bus.s_ready), 256'(0));
        chk("rst_sort_vld_in", 256'(bus.sort_vld_in), 256'(0));
        chk("rst_sort_din", bus.sort_din, 256'(0));
        chk("rst_m_valid", 256'(bus.m_valid), 256'(0));
        chk("rst_m_data", 256'(bus.m_data), 256'(0));
        chk("rst_m_last", 256'(bus.m_last), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_err_tmo", 256'(err_tmo), 256'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", 256'(bus.s_ready), 256'(1));
        chk("post_rst_busy", 256'(busy), 256'(0));

        // Full 32-entry frame
        frm.delete();
        for (int i = 31; i >= 1; i -= 2) frm.push_back(8'(i));
        for (int i = 0; i < 16; i++) frm.push_back(tail16[i]);
        send_frame(1);
        wait_idle("full");
        chk("full_err_tmo", 256'(err_tmo), 256'(0));

        // Short frame, padded
        frm = '{8'd5, 8'd250, 8'd0, 8'd7};
        send_frame(1);
        wait_idle("short");

        // Real 0xFF ties with the pad value
        frm = '{8'd255, 8'd255, 8'd1};
        send_frame(1);
        wait_idle("pad_tie");

        // Random frames under output backpressure and input gaps
        bp   = 1;
        gaps = 1;
        for (int f = 0; f < 6; f++) begin
            rand_frame($urandom_range(1, NUM));
            send_frame(1);
            wait_idle("backpressure");
        end
        bp   = 0;
        gaps = 0;

        // Sorter never answers
        dead = 1;
        rand_frame(6);
        send_frame(0);
        t_wait = 0;
        while (!err_tmo && t_wait < 200) begin
            @(negedge clk);
            t_wait++;
        end
        lat = int'(($time - fire_t) / 10);
        chk("tmo_latency", 256'(lat), 256'(SORT_TMO + 1));
        chk("tmo_s_ready", 256'(bus.s_ready), 256'(1));
        chk("tmo_busy", 256'(busy), 256'(0));
        dead = 0;
        rand_frame(9);
        send_frame(1);
        wait_idle("after_tmo");
        chk("tmo_sticky", 256'(err_tmo), 256'(1));

        // Reset in the middle of draining
        beats_done = 0;
        rand_frame(NUM);
        send_frame(1);
        t_wait = 0;
        while (beats_done < 10 && t_wait < 500) begin
            @(negedge clk);
            t_wait++;
        end
        chk("mid_drain_reached", 256'(beats_done >= 10), 256'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", 256'(bus.m_valid), 256'(0));
        chk("arst_busy", 256'(busy), 256'(0));
        chk("arst_err_tmo", 256'(err_tmo), 256'(0));
        exp_q.delete();
        exp_din.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frm = '{8'd3, 8'd1, 8'd2};
        send_frame(1);
        wait_idle("after_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
